// File: rtl/sel_arb_pkg.sv
// Shared types and defaults for the round-robin select arbiter.
package sel_arb_pkg;
  localparam int SEL_W     = 2;
  localparam int N_REQ     = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic {IDLE, GRANT} arb_state_t;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/sel_rr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request bit scanning ptr, ptr+1, ... (mod N_REQ).
module rr_pick
  import sel_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  output sel_t             pick,
  output logic             any_req
);

  sel_t idx;

  always_comb begin
    pick = '0;
    idx  = '0;
    // Walk from the farthest offset down so the nearest set bit to ptr wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) begin
        pick = idx;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/sel_rr_arbiter.sv
// Round-robin arbiter producing a registered select code with a valid/ready handshake.
// Optional per-requester grant counters are enabled by defining SEL_ARB_GRANT_CNT_EN.
module sel_rr_arbiter
  import sel_arb_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  output sel_t                   sel,
  output logic                   sel_valid,
  input  logic                   sel_ready,
  output logic [N_REQ-1:0]       grant_oh,
`ifdef SEL_ARB_GRANT_CNT_EN
  output logic                   busy,
  output logic [N_REQ*CNT_W-1:0] grant_cnt
`else
  output logic                   busy
`endif
);

  // Handshake: a grant transfers on any edge where sel_valid and sel_ready are
  // both high; sel_ready is ignored while sel_valid is low, and a pending grant
  // is never retracted or altered by request changes.
  arb_state_t state_q, state_d;
  sel_t       sel_q, sel_d;
  sel_t       ptr_q, ptr_d;
  logic       hs;
  sel_t       pick;
  logic       any_req;

  assign sel_valid = (state_q == GRANT);
  assign busy      = sel_valid;
  assign sel       = sel_q;
  assign grant_oh  = sel_valid ? (N_REQ'(1) << sel_q) : '0;
  assign hs        = sel_valid & sel_ready;

  // The same-edge re-arbitration must already see the advanced pointer.
  assign ptr_d = hs ? (sel_q + sel_t'(1)) : ptr_q;

  rr_pick u_rr_pick (
    .req     (req),
    .ptr     (ptr_d),
    .pick    (pick),
    .any_req (any_req)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          sel_d   = pick;
        end
      end
      GRANT: begin
        if (hs) begin
          if (any_req) begin
            sel_d = pick;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef SEL_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];

  always_comb begin
    cnt_d = cnt_q;
    // Saturating count of completed handshakes per requester.
    if (hs && (cnt_q[sel_q] != '1)) begin
      cnt_d[sel_q] = cnt_q[sel_q] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt_out
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_sel_rr_arbiter.sv
// Self-checking bench for sel_rr_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural round-robin model.
module tb_sel_rr_arbiter;
  localparam int N     = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         sel_ready = 1'b0;
  logic [1:0]   sel;
  logic         sel_valid;
  logic [N-1:0] grant_oh;
  logic         busy;
`ifdef SEL_ARB_GRANT_CNT_EN
  logic [N*CNT_W-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  sel_rr_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .sel       (sel),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .grant_oh  (grant_oh),
`ifdef SEL_ARB_GRANT_CNT_EN
    .busy      (busy),
    .grant_cnt (grant_cnt)
`else
    .busy      (busy)
`endif
  );

  // ---------------- reference model ----------------
  int m_ptr;
  int m_sel;
  bit m_valid;
  int m_cnt [N];

  function automatic int first_from(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic rdy, input logic rst);
    if (!rst) begin
      m_valid = 0;
      m_sel   = 0;
      m_ptr   = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (m_valid && rdy) begin
      if (m_cnt[m_sel] < CMAX) m_cnt[m_sel]++;
      m_ptr = (m_sel + 1) % N;
      if (r != 0) m_sel = first_from(r, m_ptr);
      else m_valid = 0;
    end else if (!m_valid && r != 0) begin
      m_valid = 1;
      m_sel   = first_from(r, m_ptr);
    end
  endtask

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    check("sel", 32'(sel), 32'(m_sel));
    check("sel_valid", 32'(sel_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_valid));
    check("grant_oh", 32'(grant_oh), m_valid ? (32'd1 << m_sel) : 32'd0);
`ifdef SEL_ARB_GRANT_CNT_EN
    for (int i = 0; i < N; i++)
      check("grant_cnt", 32'(grant_cnt[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
`endif
  endtask

  // ---------------- driver ----------------
  // Apply inputs, take one rising edge, then compare #1 later.
  task automatic cycle(input logic [N-1:0] r, input logic rdy, input logic rst);
    req       = r;
    sel_ready = rdy;
    rst_n     = rst;
    @(posedge clk);
    model_edge(r, rdy, rst);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    cycle('0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_ptr = 0; m_sel = 0; m_valid = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;

    // Reset held with all requests asserted.
    for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b0, 1'b0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_valid", 32'(sel_valid), 32'd0);
    check("rst_oh", 32'(grant_oh), 32'd0);
    cycle(4'b1111, 1'b0, 1'b1);
    check("rel_sel", 32'(sel), 32'd0);
    check("rel_valid", 32'(sel_valid), 32'd1);
    check("rel_oh", 32'(grant_oh), 32'b0001);

    // Round-robin wrap under continuous ready.
    exp_q = '{1, 2, 3, 0, 1};
    while (exp_q.size() > 0) begin
      cycle(4'b1111, 1'b1, 1'b1);
      check("rr_seq", 32'(sel), exp_q.pop_front());
      check("rr_valid", 32'(sel_valid), 32'd1);
    end

    // Stall stability, then release.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(4'b0100, 1'b0, 1'b1);
    cycle(4'b0010, 1'b0, 1'b1);
    check("stall_sel", 32'(sel), 32'd2);
    check("stall_valid", 32'(sel_valid), 32'd1);
    cycle(4'b0010, 1'b1, 1'b1);
    check("unstall_sel", 32'(sel), 32'd1);

    // Fairness skip after a grant to requester 3.
    do_reset();
    cycle(4'b1000, 1'b0, 1'b1);
    check("skip_g3", 32'(sel), 32'd3);
    exp_q = '{1, 3, 1};
    while (exp_q.size() > 0) begin
      cycle(4'b1010, 1'b1, 1'b1);
      check("skip_seq", 32'(sel), exp_q.pop_front());
    end

    // Drain to IDLE; sel keeps its last value.
    do_reset();
    cycle(4'b0001, 1'b1, 1'b1);
    check("drain_grant", 32'(sel_valid), 32'd1);
    cycle(4'b0000, 1'b1, 1'b1);
    check("drain_valid", 32'(sel_valid), 32'd0);
    check("drain_sel", 32'(sel), 32'd0);
    cycle(4'b0000, 1'b1, 1'b1);
    check("idle_valid", 32'(sel_valid), 32'd0);

    // Mid-grant reset discards the pending grant and the pointer.
    do_reset();
    cycle(4'b0100, 1'b0, 1'b1);
    check("mid_pre", 32'(sel), 32'd2);
    cycle(4'b0100, 1'b0, 1'b0);
    check("mid_valid", 32'(sel_valid), 32'd0);
    check("mid_sel", 32'(sel), 32'd0);
    cycle(4'b1111, 1'b0, 1'b1);
    check("mid_ptr0", 32'(sel), 32'd0);

`ifdef SEL_ARB_GRANT_CNT_EN
    // Counter saturation on requester 0.
    do_reset();
    for (int i = 0; i < 300; i++) cycle(4'b0001, 1'b1, 1'b1);
    check("sat_cnt0", 32'(grant_cnt[0 +: CNT_W]), 32'(CMAX));
    for (int i = 1; i < N; i++)
      check("sat_other", 32'(grant_cnt[i*CNT_W +: CNT_W]), 32'd0);
`endif

    // Random traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      logic [N-1:0] r;
      logic         rdy;
      logic         rst;
      r   = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 99) != 0);
      cycle(r, rdy, rst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
